// File: rtl/booth_divider.sv
// ---------------------------------------------------------------------------
// booth_divider
//
// Sequential signed divider: 8-bit signed dividend / 4-bit signed divisor ->
// 8-bit signed quotient + 4-bit signed remainder, truncating toward zero.
// Works on magnitudes with a one-bit-per-cycle restoring loop, then applies
// the signs in a final fix-up cycle. Pairs with the 4x4 signed Booth
// multiplier so a product can be divided back into its operands.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; aborts any operation
//   start      request, sampled only while idle
//   dividend   8-bit signed dividend, captured on the accepting edge
//   divisor    4-bit signed divisor, captured on the accepting edge
//   quotient   8-bit signed quotient, held until the next completion
//   remainder  4-bit signed remainder, sign follows the dividend
//   busy       high while an operation is in progress
//   done       one-cycle pulse when the result registers update
//   div_zero   last completed operation had a zero divisor
//   ovf        last completed operation was -128 / -1
// ---------------------------------------------------------------------------
module booth_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  // Partial remainder stays below |divisor| <= 8 between iterations, so four
  // bits hold it; the 5-bit working value only exists after the shift.
  logic [3:0] prem;
  // Dividend magnitude shifts out of the top while quotient bits enter at
  // the bottom; after eight iterations it holds the quotient magnitude.
  logic [7:0] qm;
  logic [3:0] dvs_m;
  logic       sgn_dd;
  logic       sgn_dv;
  logic       dz;

  logic [4:0] shifted;
  logic       ge;
  logic [3:0] trial;
  logic [7:0] dd_mag;
  logic [3:0] dv_mag;
  logic [7:0] q_signed;
  logic [3:0] r_signed;

  // NOTE: every combinational output is assigned on every path through this
  // block, so no latch can be inferred.
  always_comb begin
    shifted  = {prem, qm[7]};
    ge       = (shifted >= {1'b0, dvs_m});
    // Only taken when ge is set, in which case the difference is < |divisor|
    // and its low four bits are exact.
    trial    = shifted[3:0] - dvs_m;
    // Two's-complement negate in the operand width: -128 -> 128, -8 -> 8.
    dd_mag   = dividend[7] ? -dividend : dividend;
    dv_mag   = divisor[3]  ? -divisor  : divisor;
    // A magnitude of 128 with a negative sign wraps to 8'h80, which is -128.
    q_signed = (sgn_dd ^ sgn_dv) ? -qm : qm;
    r_signed = sgn_dd ? -prem : prem;
  end

  // Control and result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 4'h0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= (divisor == 4'h0) ? FIX : RUN;
          end
        end
        RUN: begin
          if (cnt == 4'd1) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient  <= 8'h00;
            remainder <= 4'h0;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
            div_zero  <= 1'b0;
            // Only -128 / -1 yields magnitude 128 with a positive sign.
            ovf       <= (qm == 8'h80) && !(sgn_dd ^ sgn_dv);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers.
  // NOTE: these carry no reset; they are always loaded on the accepting edge
  // before anything reads them, and the control FSM gates every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sgn_dd <= dividend[7];
      sgn_dv <= divisor[3];
      qm     <= dd_mag;
      dvs_m  <= dv_mag;
      prem   <= 4'h0;
      cnt    <= 4'd8;
      dz     <= (divisor == 4'h0);
    end else if (state == RUN) begin
      prem <= ge ? trial : shifted[3:0];
      qm   <= {qm[6:0], ge};
      cnt  <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// ---------------------------------------------------------------------------
// tb_booth_divider
//
// Directed and randomized checks of booth_divider against an arithmetic
// reference (integer / and %, plus the zero-divisor and -128/-1 cases).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_booth_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [3:0] divisor = 4'h0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic       ovf;

  int vectors = 0;
  int miscompares = 0;

  booth_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  task automatic model(input logic [7:0] dd, input logic [3:0] dv,
                       output logic [7:0] q, output logic [3:0] r,
                       output logic dz, output logic ov);
    int a;
    int b;
    a  = int'($signed(dd));
    b  = int'($signed(dv));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = 8'h00;
      r  = 4'h0;
      dz = 1'b1;
    end else if (a == -128 && b == -1) begin
      q  = 8'h80;
      r  = 4'h0;
      ov = 1'b1;
    end else begin
      q = 8'(a / b);
      r = 4'(a % b);
    end
  endtask

  // Advance until done is seen or the cycle budget runs out.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] dd,
                              input logic [3:0] dv, input int cyc);
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    model(dd, dv, q, r, dz, ov);
    check({tag, ".latency"}, 32'(cyc), dz ? 32'd1 : 32'd9);
    check({tag, ".quotient"}, 32'(quotient), 32'(q));
    check({tag, ".remainder"}, 32'(remainder), 32'(r));
    check({tag, ".div_zero"}, 32'(div_zero), 32'(dz));
    check({tag, ".ovf"}, 32'(ovf), 32'(ov));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  // One complete operation with a single-cycle start pulse.
  task automatic run_op(input string tag, input logic [7:0] dd,
                        input logic [3:0] dv);
    int cyc;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check_result(tag, dd, dv, cyc);
    tick();
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("reset.quotient", 32'(quotient), 32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.div_zero", 32'(div_zero), 32'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // 42 / 5 with busy-duration measurement.
    dividend = 8'h2A;
    divisor  = 4'h5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    cyc      = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check("p42_5.busy_cycles", 32'(busy_cnt), 32'd9);
    check_result("p42_5", 8'h2A, 4'h5, cyc);
    tick();

    // Signs and extremes.
    run_op("n42_5", 8'hD6, 4'h5);
    run_op("p42_n5", 8'h2A, 4'hB);
    run_op("n128_n1", 8'h80, 4'hF);
    run_op("n128_n8", 8'h80, 4'h8);
    run_op("n128_p1", 8'h80, 4'h1);
    run_op("p127_7", 8'h7F, 4'h7);
    run_op("p127_n8", 8'h7F, 4'h8);

    // Divide by zero, then a valid op clears the flag.
    run_op("p7_0", 8'h07, 4'h0);
    run_op("after_dz", 8'h09, 4'h2);

    // A start pulse during RUN is ignored.
    dividend = 8'd10;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    tick();
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(cyc);
    check_result("ignore_run", 8'd10, 4'd3, cyc + 3);
    tick();

    // start held high through done: second op accepted on the next edge.
    dividend = 8'd42;
    divisor  = 4'd5;
    start    = 1'b1;
    tick();
    wait_done(cyc);
    check_result("b2b_a", 8'd42, 4'd5, cyc);
    dividend = 8'd100;
    divisor  = 4'd3;
    tick();
    check("b2b.busy_restart", 32'(busy), 32'd1);
    check("b2b.done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(cyc);
    check_result("b2b_b", 8'd100, 4'd3, cyc);
    tick();

    // Reset mid-run (rst sampled at E4), no done afterwards.
    run_op("pre_rst", 8'hD6, 4'h5);
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.quotient", 32'(quotient), 32'd0);
    check("midrst.remainder", 32'(remainder), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.div_zero", 32'(div_zero), 32'd0);
    check("midrst.ovf", 32'(ovf), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    check("midrst.no_done", 32'(done_cnt), 32'd0);
    run_op("post_rst", 8'd100, 4'd3);

    // Randomized operands, about one in sixteen with a zero divisor.
    for (int i = 0; i < 200; i++) begin
      run_op("rand", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed divider, the inverse of the team's 4x4 signed Booth multiplier. It takes an 8-bit signed dividend (product width) and a 4-bit signed divisor (operand width). It returns an 8-bit signed quotient and a 4-bit signed remainder using truncating division. It runs as a one-bit-per-cycle restoring divider on magnitudes with a start/busy/done handshake, so it can sit on the same datapath as the multiplier and undo a multiply.

## Interface
- No parameters; widths fixed at 8-bit dividend, 4-bit divisor.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  8  signed dividend; captured on the accepting edge.
- divisor  input  4  signed divisor; captured on the accepting edge.
- quotient  output  8  signed quotient, registered; holds until the next completion.
- remainder  output  4  signed remainder, registered; sign follows the dividend.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the results update.
- div_zero  output  1  divisor was 0 for the last completed operation.
- ovf  output  1  true quotient not representable in 8 bits (only -128 / -1).

## Operation
- States are IDLE, RUN and FIX. The output registers quotient, remainder, div_zero and ovf change only on a done edge.
- IDLE with start=1 (edge E0):
  - Capture both operand signs.
  - Capture |dividend| as 8-bit unsigned, so -128 gives 128.
  - Capture |divisor| as 4-bit unsigned, so -8 gives 8.
  - Clear the 5-bit partial remainder, set the iteration counter to 8, set busy=1 and go to RUN.
- Divide-by-zero path: if the divisor is 0 at E0, skip RUN and go to FIX directly.
- RUN, one iteration per edge (E1..E8):
  - Shift {partial remainder, magnitude quotient} left one bit, bringing in the next dividend MSB.
  - Compute the trial value partial remainder minus |divisor|, 5-bit unsigned.
  - If non-negative, keep the difference and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - Decrement the counter; after the 8th iteration go to FIX.
- FIX, one edge:
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative.
  - Quotient result wraps mod 256.
  - Load the output registers, pulse done=1, drop busy, return to IDLE.
- Divide-by-zero results: quotient=8'h00, remainder=4'h0, div_zero=1, ovf=0.
- Overflow result: -128 / -1 gives magnitude 128, positive sign. quotient=8'h80, remainder=0, ovf=1.
- In every other case ovf=0 and div_zero=0.
- Invariant when div_zero=0 and ovf=0: dividend = quotient*divisor + remainder, and |remainder| < |divisor|. The remainder magnitude is at most 7, so it always fits in 4 bits.
- start while busy is ignored and not queued. Operands presented during RUN are not sampled.
- Back-to-back operation: start may be high in the cycle done is high. It is accepted on the first edge after the FIX edge, since the block is in IDLE then.

## Timing
- Reset, on any edge with rst=1 regardless of state:
  - State goes to IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_zero=0, ovf=0.
  - An operation in progress is aborted with no done pulse.
  - rst takes priority over start.
- Normal latency: start accepted at E0, busy=1 after E0, done=1 after E9.
  - Results are visible in the cycle after E9, which is 9 cycles after acceptance.
  - busy=0 in that same cycle.
- Divide-by-zero latency: done after E1.
- done is high for exactly one cycle per accepted start.
- Throughput: one operation per 10 cycles (normal) or per 2 cycles (divide-by-zero).

## Test plan
- 42 / 5 (8'h2A, 4'h5): quotient=8'h08, remainder=4'h2, done exactly 9 cycles after the accepting edge, busy high for 9 cycles.
- -42 / 5 (8'hD6, 4'h5) -> quotient=8'hF8 (-8), remainder=4'hE (-2). Also 42 / -5 -> quotient=8'hF8, remainder=4'h2. All flags 0.
- Extremes:
  - -128 / -1 -> quotient=8'h80, remainder=0, ovf=1.
  - -128 / -8 -> quotient=8'h10, remainder=0, ovf=0.
  - 127 / 7 -> quotient=8'h12, remainder=4'h1.
- 7 / 0 -> done one cycle after acceptance, quotient=0, remainder=0, div_zero=1. The next valid op clears div_zero.
- Handshake:
  - Pulse start with different operands during RUN -> ignored, and the original result is delivered.
  - start held high through done -> a second op begins on the next edge.
- Reset mid-run: assert rst at E4 -> all outputs 0 next cycle, no done pulse. A following 100 / 3 gives quotient=8'h21, remainder=4'h1.
